// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed 4-digit seven-segment anode scanner
// Cycles through enabled digits with a fixed on-time and optional blanking gap.
module seven_seg_scanner #(
    parameter int DIV   = 100000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_en,
    output logic [3:0] anode,
    output logic [1:0] digit_idx,
    output logic       frame_done
);

    localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam bit HAS_GAP = (BLANK > 0);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       anode_q, anode_d;
    logic             frame_done_q, frame_done_d;
    logic             active;
    logic             advance;
    logic [1:0]       next_idx;

    // First enabled digit at or after start, walking upward with wrap.
    function automatic logic [1:0] first_enabled(input logic [1:0] start,
                                                 input logic [3:0] mask);
        logic [1:0] cand;
        logic [1:0] res;
        res = start;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (mask[cand]) res = cand;
        end
        return res;
    endfunction

    always_comb begin
        active       = en && (digit_en != 4'b0000);
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        anode_d      = 4'b1111;
        frame_done_d = 1'b0;
        advance      = 1'b0;
        next_idx     = first_enabled(idx_q + 2'd1, digit_en);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (active) begin
                    state_d = SHOW;
                    idx_d   = first_enabled(idx_q, digit_en);
                end
            end
            SHOW: begin
                if (!active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST || !digit_en[idx_q]) begin
                    if (HAS_GAP) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (!active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A wrap to an equal or lower index marks the start of a new frame.
        if (advance) begin
            state_d      = SHOW;
            idx_d        = next_idx;
            cnt_d        = '0;
            frame_done_d = (next_idx <= idx_q);
        end

        if (state_d == SHOW) anode_d = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            anode_q      <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
// Two instances (BLANK=2 and BLANK=0) share stimulus and are tracked by a slot-timer model.
module tb_seven_seg_scanner;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] digit_en = 4'b0000;
    logic [3:0] an_a, an_b;
    logic [1:0] idx_a, idx_b;
    logic       fd_a, fd_b;

    int vectors = 0;
    int fails   = 0;

    // Model: mode 0=dark/idle, 1=showing, 2=gap; left = cycles remaining in slot.
    int m_mode[2];
    int m_left[2];
    int m_idx[2];
    bit m_fd[2];

    always #5 clk = ~clk;

    seven_seg_scanner #(.DIV(DIV), .BLANK(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .digit_en(digit_en),
        .anode(an_a), .digit_idx(idx_a), .frame_done(fd_a)
    );

    seven_seg_scanner #(.DIV(DIV), .BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .digit_en(digit_en),
        .anode(an_b), .digit_idx(idx_b), .frame_done(fd_b)
    );

    function automatic int search(int start, logic [3:0] mask);
        for (int k = 0; k < 4; k++)
            if (mask[(start + k) % 4]) return (start + k) % 4;
        return start % 4;
    endfunction

    function automatic logic [3:0] exp_an(int c);
        logic [3:0] v;
        v = 4'b1111;
        if (m_mode[c] == 1) v[m_idx[c]] = 1'b0;
        return v;
    endfunction

    task automatic model_step(int c, int blank);
        int old;
        bit adv;
        adv = 0;
        m_fd[c] = 0;
        if (rst) begin
            m_mode[c] = 0; m_idx[c] = 0; m_left[c] = 0;
        end else if (!(en && digit_en != 4'b0000)) begin
            m_mode[c] = 0;
        end else if (m_mode[c] == 0) begin
            m_idx[c] = search(m_idx[c], digit_en);
            m_mode[c] = 1; m_left[c] = DIV;
        end else if (m_mode[c] == 1) begin
            m_left[c]--;
            if (m_left[c] == 0 || !digit_en[m_idx[c]]) begin
                if (blank > 0) begin
                    m_mode[c] = 2; m_left[c] = blank;
                end else adv = 1;
            end
        end else begin
            m_left[c]--;
            if (m_left[c] == 0) adv = 1;
        end
        if (adv) begin
            old = m_idx[c];
            m_idx[c] = search(old + 1, digit_en);
            m_mode[c] = 1; m_left[c] = DIV;
            m_fd[c] = (m_idx[c] <= old);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 2);
        model_step(1, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Anode must never select more than one digit, in any test.
    always @(negedge clk) begin
        if (!$isunknown(an_a) && !$isunknown(an_b)) begin
            vectors++;
            if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
                fails++;
                $display("FAIL onehot: anode_a=%b anode_b=%b, required at most one low bit", an_a, an_b);
            end
        end
    end

    task automatic test_reset();
        en = 1'b1;
        digit_en = 4'($urandom);
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (an_a !== 4'b1111 || idx_a !== 2'd0 || fd_a !== 1'b0 ||
            an_b !== 4'b1111 || idx_b !== 2'd0 || fd_b !== 1'b0) begin
            fails++;
            $display("FAIL reset: a=%b/%0d/%b b=%b/%0d/%b, required 1111/0/0", an_a, idx_a, fd_a, an_b, idx_b, fd_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan(string name, logic [3:0] mask, int cycles, int period_a);
        int last_fd, pulses;
        do_reset();
        en = 1'b1;
        digit_en = mask;
        last_fd = -1;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            vectors++;
            if (an_a !== exp_an(0) || idx_a !== 2'(m_idx[0]) || fd_a !== m_fd[0]) begin
                fails++;
                $display("FAIL %s a cyc%0d: anode=%b idx=%0d fd=%b, required %b/%0d/%b", name, i, an_a, idx_a, fd_a, exp_an(0), m_idx[0], m_fd[0]);
            end
            vectors++;
            if (an_b !== exp_an(1) || idx_b !== 2'(m_idx[1]) || fd_b !== m_fd[1]) begin
                fails++;
                $display("FAIL %s b cyc%0d: anode=%b idx=%0d fd=%b, required %b/%0d/%b", name, i, an_b, idx_b, fd_b, exp_an(1), m_idx[1], m_fd[1]);
            end
            if (fd_a === 1'b1) begin
                if (last_fd >= 0) begin
                    vectors++;
                    if (i - last_fd != period_a) begin
                        fails++;
                        $display("FAIL %s period: got %0d cycles, required %0d", name, i - last_fd, period_a);
                    end
                end
                last_fd = i;
                pulses++;
            end
        end
        vectors++;
        if (pulses < 2) begin
            fails++;
            $display("FAIL %s pulses: got %0d frame_done pulses, required at least 2", name, pulses);
        end
    endtask

    task automatic test_en_drop();
        int guard;
        do_reset();
        en = 1'b1;
        digit_en = 4'b1111;
        guard = 0;
        while (!(m_mode[0] == 1 && m_idx[0] == 2 && m_left[0] == DIV - 1) && guard < 100) begin
            tick();
            guard++;
        end
        vectors++;
        if (guard >= 100) begin
            fails++;
            $display("FAIL en_drop setup: model never reached digit 2 second cycle, got %0d ticks, required <100", guard);
        end
        en = 1'b0;
        tick();
        vectors++;
        if (an_a !== 4'b1111 || idx_a !== 2'd2 || fd_a !== 1'b0) begin
            fails++;
            $display("FAIL en_drop dark: anode=%b idx=%0d fd=%b, required 1111/2/0", an_a, idx_a, fd_a);
        end
        en = 1'b1;
        for (int i = 0; i < DIV + 3; i++) begin
            tick();
            vectors++;
            if (an_a !== (i < DIV ? 4'b1011 : (i < DIV + 2 ? 4'b1111 : 4'b0111)) || fd_a !== 1'b0) begin
                fails++;
                $display("FAIL en_drop resume cyc%0d: anode=%b fd=%b, required %b/0", i, an_a, fd_a, (i < DIV ? 4'b1011 : (i < DIV + 2 ? 4'b1111 : 4'b0111)));
            end
        end
    endtask

    task automatic test_rst_mid_gap();
        int guard;
        do_reset();
        en = 1'b1;
        digit_en = 4'b1111;
        guard = 0;
        while (!(m_mode[0] == 2 && m_idx[0] == 1) && guard < 100) begin
            tick();
            guard++;
        end
        vectors++;
        if (guard >= 100 || an_a !== 4'b1111 || idx_a !== 2'd1) begin
            fails++;
            $display("FAIL rst_gap setup: anode=%b idx=%0d after %0d ticks, required 1111/1", an_a, idx_a, guard);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (an_a !== 4'b1111 || idx_a !== 2'd0 || fd_a !== 1'b0) begin
            fails++;
            $display("FAIL rst_gap reset: anode=%b idx=%0d fd=%b, required 1111/0/0", an_a, idx_a, fd_a);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (an_a !== 4'b1110 || idx_a !== 2'd0 || fd_a !== 1'b0) begin
            fails++;
            $display("FAIL rst_gap restart: anode=%b idx=%0d fd=%b, required 1110/0/0", an_a, idx_a, fd_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        digit_en = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            vectors++;
            if (an_a !== exp_an(0) || idx_a !== 2'(m_idx[0]) || fd_a !== m_fd[0]) begin
                fails++;
                $display("FAIL random a cyc%0d: anode=%b idx=%0d fd=%b, required %b/%0d/%b", i, an_a, idx_a, fd_a, exp_an(0), m_idx[0], m_fd[0]);
            end
            vectors++;
            if (an_b !== exp_an(1) || idx_b !== 2'(m_idx[1]) || fd_b !== m_fd[1]) begin
                fails++;
                $display("FAIL random b cyc%0d: anode=%b idx=%0d fd=%b, required %b/%0d/%b", i, an_b, idx_b, fd_b, exp_an(1), m_idx[1], m_fd[1]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0; m_left[c] = 0; m_idx[c] = 0; m_fd[c] = 0;
        end
        test_reset();
        test_scan("full", 4'b1111, 80, 24);
        test_scan("sparse", 4'b0101, 50, 12);
        test_scan("single", 4'b1000, 30, 6);
        test_en_drop();
        test_rst_mid_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
